// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one registered add/sub datapath among NREQ requesters.
// Latency: accept at edge E, result registered at E+1, response handshake no earlier than E+2.
// Backpressure: rsp_ready low holds RESP with stable outputs; req_ready stays low until the response drains.

module addsub_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         mode,
    output logic [N-1:0] sum,
    output logic         carry
);
    logic [N:0] res;

    // Bit N of the widened difference is set exactly when a < b, which is the borrow.
    always_comb begin
        if (mode) res = {1'b0, a} - {1'b0, b};
        else      res = {1'b0, a} + {1'b0, b};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum   <= '0;
            carry <= 1'b0;
        end else if (load) begin
            sum   <= res[N-1:0];
            carry <= res[N];
        end
    end
endmodule

module addsub_arbiter #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ-1:0]     req_mode,
    input  logic [NREQ*N-1:0]   req_a,
    input  logic [NREQ*N-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [N-1:0]        rsp_sum,
    output logic                rsp_carry,
    output logic                busy,
    output logic [15:0]         op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic           mode;
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [IDW-1:0] id;
    } op_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] ptr_next;
    logic           gnt_any;
    logic           accept;
    op_t            op_q;

    // First requester at or above ptr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end
    end

    assign ptr_next = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    req_ready[gnt_id] = 1'b1;
                    accept            = 1'b1;
                    state_d           = EXEC;
                end
            end
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (reset) begin
            req_ready = '0;
            accept    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr      <= '0;
            op_q     <= '0;
            rsp_id   <= '0;
            op_count <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q.mode <= req_mode[gnt_id];
                op_q.a    <= req_a[gnt_id*N +: N];
                op_q.b    <= req_b[gnt_id*N +: N];
                op_q.id   <= gnt_id;
                ptr       <= ptr_next;
            end
            if (state_q == EXEC) rsp_id <= op_q.id;
            if (state_q == RESP && rsp_ready) op_count <= op_count + 16'd1;
        end
    end

    addsub_unit #(.N(N)) u_addsub (
        .clk   (clk),
        .reset (reset),
        .load  (state_q == EXEC),
        .a     (op_q.a),
        .b     (op_q.b),
        .mode  (op_q.mode),
        .sum   (rsp_sum),
        .carry (rsp_carry)
    );

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Round-robin arbiter and sequencer that shares one registered N-bit adder/subtractor among NREQ requesters. Each requester presents operands and a mode over a valid/ready handshake. The block grants one requester at a time, computes the sum or difference, and returns the result with the requester's index over a backpressured response channel. It sits between the requesting DSP stages and the shared arithmetic datapath, and it instantiates that datapath internally.

## Interface
- N, 32, operand and result width in bits
- NREQ, 4, number of requesters (2..16)
- IDW, $clog2(NREQ), width of the requester index (derived)

- clk  input  1  clock, rising-edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept; at most one bit high
- req_mode  input  NREQ  per-requester op: 0 = a+b, 1 = a-b
- req_a  input  NREQ*N  operand a; requester i uses bits [i*N +: N]
- req_b  input  NREQ*N  operand b; same packing as req_a
- rsp_valid  output  1  result valid
- rsp_ready  input  1  downstream accepts result
- rsp_id  output  IDW  index of the requester that owns the result
- rsp_sum  output  N  result, modulo 2^N
- rsp_carry  output  1  carry-out for add; borrow (a<b unsigned) for sub
- busy  output  1  high in EXEC or RESP
- op_count  output  16  count of completed responses, wraps 0xFFFF->0x0000

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE
  - If any req_valid is high, select grant g: the first set bit searching upward from ptr, modulo NREQ.
  - Drive req_ready[g]=1 combinationally and all other bits 0.
  - On the edge, latch a, b, mode, and id=g, go to EXEC, and set ptr = (g+1) mod NREQ.
  - If no req_valid is high, stay in IDLE and leave ptr unchanged.
- EXEC
  - Compute an (N+1)-bit result.
  - Add: {carry,sum} = a + b.
  - Sub: sum = a - b mod 2^N; borrow = (a < b) unsigned.
  - Register rsp_sum, rsp_carry and rsp_id, then go to RESP unconditionally.
- RESP
  - rsp_valid=1.
  - rsp_sum, rsp_carry and rsp_id hold stable until rsp_valid && rsp_ready.
  - On that handshake edge: go to IDLE and increment op_count.
- req_ready is 0 in EXEC and RESP. A new request is never accepted in the cycle a response completes.
- Requesters hold req_valid and their operands stable until accepted. Operand changes before acceptance are not checked.
- A requester deasserting req_valid before acceptance is legal. The next IDLE cycle arbitrates without it.
- ptr starts at 0 and advances only on a grant, so one requester cannot be granted twice while another continuously requests.

## Timing
- Reset values: state=IDLE, ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, busy=0, op_count=0.
- req_ready is forced to 0 in any cycle in which reset is high.
- Accept handshake at edge E (IDLE, req_valid[g] && req_ready[g]):
  - state=EXEC in cycle E..E+1;
  - rsp_valid=1 from edge E+1;
  - earliest rsp handshake at edge E+2;
  - earliest next accept at edge E+3.
- Peak throughput is one operation per 3 cycles. Each additional cycle of rsp_ready low adds one cycle.
- busy=1 from edge E through the response handshake edge.
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded, no response is issued, op_count and ptr are cleared, and all outputs return to their reset values on that edge.
- Simultaneous request from all NREQ requesters held continuously: grants occur in order ptr, ptr+1, ….
- Overflow wraps modulo 2^N. rsp_carry is the only overflow indication.

## Test plan
- Single request: requester 2 sends a=15, b=7, mode=0 with rsp_ready=1 → req_ready[2] pulses in the first cycle; rsp_valid 1 cycle after accept; rsp_id=2, rsp_sum=22, rsp_carry=0; op_count=1.
- Subtract with borrow: a=5, b=10, mode=1 → rsp_sum=0xFFFFFFFB, rsp_carry=1. Add wrap: a=0xFFFFFFFF, b=1, mode=0 → rsp_sum=0, rsp_carry=1.
- Fairness: all 4 req_valid held high for 12 operations with rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1,2,3,0,1,2,3; accepts exactly 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_sum and rsp_id stable; req_ready stays 0; the handshake occurs on the first cycle rsp_ready=1.
- Reset mid-op: assert reset during EXEC of a=10, b=3 → no rsp_valid pulse; after release, op_count=0 and ptr=0, and with all requesters valid the first grant goes to requester 0.
- Randomized sweep: 200 operations with random a, b, mode and random rsp_ready → every rsp_sum/rsp_carry matches the modulo-2^N model; op_count=200.
